font_loader: RTL and testbench
==============================

FONT_LOADER -- requirements
Module: font_loader

Interface
REQ-001 SHALL have parameter CHARS, default 256: number of glyphs in font RAM.
REQ-002 SHALL have parameter CHAR_HEIGHT, default 10: rows per glyph.
REQ-003 SHALL have parameter ADDR_WIDTH, default 12: font RAM address width; CHARS*CHAR_HEIGHT <= 2^ADDR_WIDTH.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  in_data holds a byte.
REQ-007 in_data  input  8  command/data byte stream.
REQ-008 in_ready  output  1  byte accepted when in_valid & in_ready at a rising edge.
REQ-009 mem_we  output  1  font RAM write strobe, one cycle per row.
REQ-010 mem_addr  output  ADDR_WIDTH  font RAM row address = index*CHAR_HEIGHT + row.
REQ-011 mem_data  output  8  row bitmap; bit 7 = leftmost pixel.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 glyph_done  output  1  one-cycle pulse after the last row of a glyph is written.
REQ-014 error  output  1  one-cycle pulse on bad opcode or out-of-range index.

Function
REQ-015 Stream format SHALL be: opcode, index, payload; opcode 0x01 = LOAD (CHAR_HEIGHT row bytes follow, row 0 first); 0x02 = FILL (one pattern byte follows).
REQ-016 States SHALL be IDLE, INDEX, LOAD_ROWS, FILL_BYTE, FILL_WRITE, DISCARD.
REQ-017 IDLE: accepted 0x01 -> INDEX (op=LOAD); 0x02 -> INDEX (op=FILL); any other byte -> error pulse, stay IDLE.
REQ-018 INDEX: accepted byte < CHARS -> base = byte*CHAR_HEIGHT registered, row counter = 0, go LOAD_ROWS or FILL_BYTE per op.
REQ-019 INDEX: accepted byte >= CHARS -> error pulse next cycle, go DISCARD with count CHAR_HEIGHT (LOAD) or 1 (FILL); no RAM writes.
REQ-020 DISCARD: in_ready=1, consume count bytes, then IDLE; no glyph_done.
REQ-021 LOAD_ROWS: in_ready=1; each accepted byte produces mem_we=1, mem_addr=base+row, mem_data=byte on the following cycle (latency 1); row increments.
REQ-022 LOAD_ROWS: accepting row CHAR_HEIGHT-1 -> IDLE; glyph_done pulses in the same cycle as that final mem_we.
REQ-023 FILL_BYTE: accept pattern byte, go FILL_WRITE; FILL_WRITE: in_ready=0, mem_we=1 for CHAR_HEIGHT consecutive cycles, rows 0..CHAR_HEIGHT-1, mem_data=pattern; glyph_done with last write; then IDLE.
REQ-024 in_ready SHALL be 1 in IDLE, INDEX, LOAD_ROWS, FILL_BYTE, DISCARD and 0 in FILL_WRITE; in_ready SHALL not depend combinationally on in_valid.
REQ-025 Gaps (in_valid=0) in any accepting state SHALL hold state, counters and base; no writes occur.
REQ-026 mem_addr and mem_data SHALL hold last values when mem_we=0; address arithmetic is ADDR_WIDTH-bit, base+row never wraps for legal parameters.
REQ-027 glyph_done and error SHALL never assert in the same cycle.

Reset
REQ-028 reset SHALL, at the next rising edge, force IDLE, row/discard counters 0, base 0, mem_we=0, mem_addr=0, mem_data=0, busy=0, glyph_done=0, error=0, in_ready=1.
REQ-029 reset mid-glyph SHALL abandon the glyph with no further writes; rows already written remain in RAM; the next accepted byte is treated as an opcode.
REQ-030 reset SHALL take priority over any simultaneous in_valid.

Verification
REQ-031 Stream 0x01,0x41,0x00,0x18,0x24,0x42,0x42,0x7E,0x42,0x42,0x00,0x00 back-to-back -> 10 writes addr 650..659 with those data, glyph_done with write to 659, busy low next cycle.
REQ-032 Stream 0x02,0x05,0xFF -> in_ready low 10 cycles, writes addr 50..59 data 0xFF, glyph_done on addr 59.
REQ-033 Byte 0x7F in IDLE -> error pulse, no write; following 0x01,0x00,10 rows loads addresses 0..9.
REQ-034 CHARS=128, stream 0x01,0x90 + 10 rows -> error pulse, zero writes, 10 rows consumed, next opcode decoded normally.
REQ-035 LOAD with in_valid toggled randomly between rows -> identical write sequence to back-to-back case, no write while in_valid=0.
REQ-036 reset asserted after row 4 of LOAD -> no further writes, outputs at reset values, new LOAD completes correctly.

Source files
------------

// File: rtl/font_loader.sv
// Font RAM loader: decodes LOAD/FILL byte commands into per-row font RAM writes.
// Latency 1 from accepted row byte to mem_we; in_ready drops only while FILL burst-writes rows.
module font_loader #(
    parameter int CHARS       = 256,
    parameter int CHAR_HEIGHT = 10,
    parameter int ADDR_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_data,
    output logic                  busy,
    output logic                  glyph_done,
    output logic                  error
);

    localparam int CW = $clog2(CHAR_HEIGHT + 1);
    localparam logic [CW-1:0] LAST_ROW = CW'(CHAR_HEIGHT - 1);
    localparam logic [CW-1:0] ROW_CNT  = CW'(CHAR_HEIGHT);

    typedef enum logic [2:0] {
        IDLE,
        INDEX,
        LOAD_ROWS,
        FILL_BYTE,
        FILL_WRITE,
        DISCARD
    } state_t;

    state_t                state, state_nx;
    logic                  op_fill, op_fill_nx;
    logic [CW-1:0]         row, row_nx;
    logic [CW-1:0]         disc, disc_nx;
    logic [ADDR_WIDTH-1:0] base, base_nx;
    logic [7:0]            pattern, pattern_nx;
    logic                  mem_we_nx;
    logic [ADDR_WIDTH-1:0] mem_addr_nx;
    logic [7:0]            mem_data_nx;
    logic                  glyph_done_nx;
    logic                  error_nx;
    logic                  accept;

    assign in_ready = (state != FILL_WRITE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_nx      = state;
        op_fill_nx    = op_fill;
        row_nx        = row;
        disc_nx       = disc;
        base_nx       = base;
        pattern_nx    = pattern;
        mem_we_nx     = 1'b0;
        mem_addr_nx   = mem_addr;
        mem_data_nx   = mem_data;
        glyph_done_nx = 1'b0;
        error_nx      = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_data == 8'h01) begin
                        op_fill_nx = 1'b0;
                        state_nx   = INDEX;
                    end else if (in_data == 8'h02) begin
                        op_fill_nx = 1'b1;
                        state_nx   = INDEX;
                    end else begin
                        error_nx = 1'b1;
                    end
                end
            end
            INDEX: begin
                if (accept) begin
                    if (32'(in_data) < CHARS) begin
                        base_nx  = ADDR_WIDTH'(in_data) * ADDR_WIDTH'(CHAR_HEIGHT);
                        row_nx   = '0;
                        state_nx = op_fill ? FILL_BYTE : LOAD_ROWS;
                    end else begin
                        // Swallow the payload so it is not misread as opcodes.
                        error_nx = 1'b1;
                        disc_nx  = op_fill ? CW'(1) : ROW_CNT;
                        state_nx = DISCARD;
                    end
                end
            end
            LOAD_ROWS: begin
                if (accept) begin
                    mem_we_nx   = 1'b1;
                    mem_addr_nx = base + ADDR_WIDTH'(row);
                    mem_data_nx = in_data;
                    if (row == LAST_ROW) begin
                        glyph_done_nx = 1'b1;
                        row_nx        = '0;
                        state_nx      = IDLE;
                    end else begin
                        row_nx = row + CW'(1);
                    end
                end
            end
            FILL_BYTE: begin
                if (accept) begin
                    pattern_nx = in_data;
                    row_nx     = '0;
                    state_nx   = FILL_WRITE;
                end
            end
            FILL_WRITE: begin
                mem_we_nx   = 1'b1;
                mem_addr_nx = base + ADDR_WIDTH'(row);
                mem_data_nx = pattern;
                if (row == LAST_ROW) begin
                    glyph_done_nx = 1'b1;
                    row_nx        = '0;
                    state_nx      = IDLE;
                end else begin
                    row_nx = row + CW'(1);
                end
            end
            DISCARD: begin
                if (accept) begin
                    if (disc <= CW'(1)) begin
                        disc_nx  = '0;
                        state_nx = IDLE;
                    end else begin
                        disc_nx = disc - CW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_fill    <= 1'b0;
            row        <= '0;
            disc       <= '0;
            base       <= '0;
            pattern    <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            glyph_done <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_nx;
            op_fill    <= op_fill_nx;
            row        <= row_nx;
            disc       <= disc_nx;
            base       <= base_nx;
            pattern    <= pattern_nx;
            mem_we     <= mem_we_nx;
            mem_addr   <= mem_addr_nx;
            mem_data   <= mem_data_nx;
            glyph_done <= glyph_done_nx;
            error      <= error_nx;
        end
    end

endmodule

// File: tb/tb_font_loader.sv
// Scoreboard bench for font_loader (CHARS=128): stimulus pushes expected writes/errors, negedge monitor pops.
module tb_font_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data;
    logic        busy;
    logic        glyph_done;
    logic        error;

    font_loader #(.CHARS(128), .CHAR_HEIGHT(10), .ADDR_WIDTH(12)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .busy(busy), .glyph_done(glyph_done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] a;
        logic [7:0]  d;
        logic        done;
    } wr_t;

    wr_t exp_q[$];
    int  exp_err  = 0;
    int  checks   = 0;
    int  failures = 0;

    logic [7:0] glyph_a [10] = '{8'h00, 8'h18, 8'h24, 8'h42, 8'h42, 8'h7E, 8'h42, 8'h42, 8'h00, 8'h00};
    logic [7:0] glyph_b [10] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    logic [7:0] glyph_c [10] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h81, 8'h7E, 8'h01, 8'h80, 8'hF0, 8'h0F};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                flag("unexpected_write", {8'h0, mem_addr, mem_data}, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.a));
                check("wr_data", 32'(mem_data), 32'(e.d));
                check("wr_done", 32'(glyph_done), 32'(e.done));
            end
        end else if (glyph_done) begin
            flag("done_without_write", 1, 0);
        end
        if (error) begin
            if (glyph_done) flag("error_with_done", 1, 0);
            if (exp_err > 0) begin
                exp_err--;
                checks++;
            end else begin
                flag("unexpected_error", 1, 0);
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) flag("send_timeout", 32'(b), 0);
    endtask

    task automatic load(input logic [7:0] idx, input logic [7:0] rows [10], input int maxgap);
        for (int r = 0; r < 10; r++)
            exp_q.push_back('{a: 12'(int'(idx) * 10 + r), d: rows[r], done: (r == 9)});
        send(8'h01, 0);
        send(idx, $urandom_range(0, maxgap));
        for (int r = 0; r < 10; r++) send(rows[r], $urandom_range(0, maxgap));
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 40 && (exp_q.size() != 0 || exp_err != 0); t++) @(negedge clk);
        repeat (2) @(negedge clk);
        check({name, "_writes_left"}, 32'(exp_q.size()), 0);
        check({name, "_errors_left"}, 32'(exp_err), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_mem_we"},   32'(mem_we), 0);
        check({name, "_mem_addr"}, 32'(mem_addr), 0);
        check({name, "_mem_data"}, 32'(mem_data), 0);
        check({name, "_busy"},     32'(busy), 0);
        check({name, "_done"},     32'(glyph_done), 0);
        check({name, "_error"},    32'(error), 0);
        check({name, "_in_ready"}, 32'(in_ready), 1);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back LOAD of 'A' at index 0x41 -> 650..659.
        load(8'h41, glyph_a, 0);
        @(negedge clk);
        check("load_busy_after", 32'(busy), 0);
        drain("load_b2b");

        // FILL index 5 with 0xFF -> 50..59, ready low for the burst.
        for (int r = 0; r < 10; r++) exp_q.push_back('{a: 12'(50 + r), d: 8'hFF, done: (r == 9)});
        send(8'h02, 0);
        send(8'h05, 0);
        send(8'hFF, 0);
        n = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        check("fill_ready_low_cycles", 32'(n), 10);
        @(posedge clk);
        #1;
        drain("fill");

        // Bad opcode, then a normal LOAD at index 0.
        exp_err++;
        send(8'h7F, 0);
        load(8'h00, glyph_b, 0);
        drain("bad_opcode");

        // Out-of-range LOAD index: 10 rows swallowed, no writes.
        exp_err++;
        send(8'h01, 0);
        send(8'h90, 0);
        for (int r = 0; r < 10; r++) send(8'h01, 0);
        load(8'h03, glyph_c, 0);
        drain("oob_load");

        // Out-of-range FILL index at the boundary: one pattern byte swallowed.
        exp_err++;
        send(8'h02, 0);
        send(8'h80, 0);
        send(8'h02, 0);
        load(8'h7F, glyph_c, 0);
        drain("oob_fill");

        // Random gaps between bytes must not change the write sequence.
        load(8'h41, glyph_a, 3);
        drain("load_gaps");

        // Reset after row 4, with a competing opcode byte on the reset edge.
        for (int r = 0; r < 5; r++) exp_q.push_back('{a: 12'(70 + r), d: glyph_b[r], done: 1'b0});
        send(8'h01, 0);
        send(8'h07, 0);
        for (int r = 0; r < 5; r++) send(glyph_b[r], 0);
        @(negedge clk);
        check("mid_glyph_busy", 32'(busy), 1);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h01;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #1;
        load(8'h02, glyph_a, 1);
        drain("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
